event_stimulus_gen: RTL and testbench

EVENT_STIMULUS_GEN -- requirements
Module: event_stimulus_gen

---
 rtl/event_pkg.sv | 18 +
 rtl/event_timer.sv | 74 +++++++
 rtl/event_stimulus_gen.sv | 135 +++++++++++++
 tb/tb_event_stimulus_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/event_pkg.sv
// rtl/event_pkg.sv - shared types and default widths for the event stimulus generator
//
// Purpose: FSM state encoding and default counter/accounting widths used by
//          event_stimulus_gen and event_timer.
// Ports:   none (package).
package event_pkg;

  localparam int CNT_W_DEFAULT = 8;
  localparam int ACK_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/event_timer.sv
// rtl/event_timer.sv - parameter clamp/latch and per-event HIGH/LOW cycle counter
//
// Purpose: captures period/high_cycles/burst_len when a burst is accepted,
//          clamps them to legal values and counts cycles within each event.
// Ports:   clk, reset        - clock, synchronous active-high reset
//          load              - start accepted this cycle (latch + restart count)
//          run               - FSM is in HIGH or LOW
//          period, high_cycles, burst_len - raw burst configuration
//          high_last         - current cycle is the last HIGH cycle of the event
//          event_last        - current cycle is the last LOW cycle of the event
//          second_cycle      - current cycle is the second cycle of the event
//          burst_len_q       - latched burst length (0 = continuous)
module event_timer
  import event_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] burst_len,
  output logic             high_last,
  output logic             event_last,
  output logic             second_cycle,
  output logic [CNT_W-1:0] burst_len_q
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  logic [CNT_W-1:0] period_c;
  logic [CNT_W-1:0] high_c;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] cnt;

  // An event needs at least one HIGH and one LOW cycle, so the high time is
  // clamped against the already-clamped period.
  always_comb begin
    period_c = (period < CNT_TWO) ? CNT_TWO : period;
    if (high_cycles == '0) begin
      high_c = CNT_ONE;
    end else if (high_cycles >= period_c) begin
      high_c = period_c - CNT_ONE;
    end else begin
      high_c = high_cycles;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q    <= '0;
      high_q      <= '0;
      burst_len_q <= '0;
      cnt         <= '0;
    end else if (load) begin
      period_q    <= period_c;
      high_q      <= high_c;
      burst_len_q <= burst_len;
      cnt         <= '0;
    end else if (run) begin
      // cnt is the position within the current event: 0 .. period-1.
      cnt <= event_last ? '0 : cnt + CNT_ONE;
    end
  end

  assign high_last    = (cnt == high_q - CNT_ONE);
  assign event_last   = (cnt == period_q - CNT_ONE);
  assign second_cycle = (cnt == CNT_ONE);

endmodule

// File: rtl/event_stimulus_gen.sv
// rtl/event_stimulus_gen.sv - burst generator driving an event monitor with ack/miss accounting
//
// Purpose: produces bursts of HIGH/LOW events on enable/data_signal, tracks
//          whether the downstream monitor acknowledged each event, and ends a
//          burst on burst length or a pending stop.
// Ports:   clk, reset        - clock, synchronous active-high reset
//          start, stop       - begin a burst (IDLE only) / end after current event
//          period, high_cycles, burst_len - burst configuration, latched on start
//          event_occurred    - monitor feedback, sampled in each event's second cycle
//          enable, data_signal - monitor drive
//          busy, done        - burst running / one-cycle end-of-burst pulse
//          ack_count, miss_count - saturating per-burst event accounting
module event_stimulus_gen
  import event_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int ACK_W = ACK_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             event_occurred,
  output logic             enable,
  output logic             data_signal,
  output logic             busy,
  output logic             done,
  output logic [ACK_W-1:0] ack_count,
  output logic [ACK_W-1:0] miss_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ACK_W-1:0] ACK_ONE = ACK_W'(1);

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             run;
  logic             end_burst;
  logic             stop_pend;
  logic [CNT_W-1:0] evt_cnt;
  logic             high_last;
  logic             event_last;
  logic             second_cycle;
  logic [CNT_W-1:0] burst_len_q;

  assign accept = (state == ST_IDLE) && start;
  assign run    = (state == ST_HIGH) || (state == ST_LOW);

  event_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load         (accept),
    .run          (run),
    .period       (period),
    .high_cycles  (high_cycles),
    .burst_len    (burst_len),
    .high_last    (high_last),
    .event_last   (event_last),
    .second_cycle (second_cycle),
    .burst_len_q  (burst_len_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A stop raised in the very last LOW cycle still ends the burst after
  // this event, so the live stop is ORed with the pending flag.
  always_comb begin
    next_state = state;
    end_burst  = ((burst_len_q != '0) && (evt_cnt + CNT_ONE == burst_len_q))
                 || stop_pend || stop;
    unique case (state)
      ST_IDLE:  if (start) next_state = ST_HIGH;
      ST_HIGH:  if (high_last) next_state = ST_LOW;
      ST_LOW:   if (event_last) next_state = end_burst ? ST_DRAIN : ST_HIGH;
      ST_DRAIN: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so they are registered yet line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable      <= 1'b0;
      data_signal <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      stop_pend   <= 1'b0;
      evt_cnt     <= '0;
      ack_count   <= '0;
      miss_count  <= '0;
    end else begin
      enable      <= (next_state == ST_HIGH) || (next_state == ST_LOW);
      data_signal <= (next_state == ST_HIGH);
      busy        <= (next_state == ST_HIGH) || (next_state == ST_LOW);
      done        <= (next_state == ST_DRAIN);
      if (accept) begin
        stop_pend  <= 1'b0;
        evt_cnt    <= '0;
        ack_count  <= '0;
        miss_count <= '0;
      end else begin
        if (state == ST_DRAIN) begin
          stop_pend <= 1'b0;
        end else if (run && stop) begin
          stop_pend <= 1'b1;
        end
        // Free-running when burst_len is 0; wrapping is harmless there.
        if (run && event_last) begin
          evt_cnt <= evt_cnt + CNT_ONE;
        end
        if (run && second_cycle) begin
          if (event_occurred) begin
            if (ack_count != '1) ack_count <= ack_count + ACK_ONE;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + ACK_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_event_stimulus_gen.sv
// tb/tb_event_stimulus_gen.sv - directed and randomized bench for event_stimulus_gen
module tb_event_stimulus_gen;

  localparam int CNT_W   = 8;
  localparam int ACK_W   = 3;
  localparam int ACK_MAX = (1 << ACK_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] burst_len;
  logic             event_occurred;
  logic             enable;
  logic             data_signal;
  logic             busy;
  logic             done;
  logic [ACK_W-1:0] ack_count;
  logic [ACK_W-1:0] miss_count;

  int checks   = 0;
  int failures = 0;
  int exp_ack;
  int exp_miss;

  always #5 clk = ~clk;

  event_stimulus_gen #(
    .CNT_W(CNT_W),
    .ACK_W(ACK_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .period         (period),
    .high_cycles    (high_cycles),
    .burst_len      (burst_len),
    .event_occurred (event_occurred),
    .enable         (enable),
    .data_signal    (data_signal),
    .busy           (busy),
    .done           (done),
    .ack_count      (ack_count),
    .miss_count     (miss_count)
  );

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_enable"}, -1, 32'(enable), 32'd0);
    check({tag, "_data"},   -1, 32'(data_signal), 32'd0);
    check({tag, "_busy"},   -1, 32'(busy), 32'd0);
    check({tag, "_done"},   -1, 32'(done), 32'd0);
  endtask

  // Model: after acceptance, cycle k lies in event k/pe at position k%pe and
  // is high when position < he. The burst lasts bl*pe cycles, or ends at the
  // close of the event in which stop was seen; then one done cycle, then idle.
  task automatic run_burst(input string name, input int p, input int h, input int bl,
                           input int stop_k, input int restart_k, input bit mon,
                           input bit stop_with_start);
    int pe;
    int he;
    int total;
    bit mon_q;
    pe = (p < 2) ? 2 : p;
    he = (h == 0) ? 1 : ((h >= pe) ? pe - 1 : h);
    total = (bl != 0) ? bl * pe : (1 << 20);
    if (stop_k >= 0 && stop_k < total) total = (stop_k / pe + 1) * pe;
    exp_ack  = 0;
    exp_miss = 0;
    mon_q    = 1'b0;
    period      = CNT_W'(p);
    high_cycles = CNT_W'(h);
    burst_len   = CNT_W'(bl);
    start          = 1'b1;
    stop           = stop_with_start;
    event_occurred = 1'b0;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    for (int k = 0; k < total + 3; k++) begin
      bit e_run;
      bit e_data;
      bit e_done;
      bit occ;
      e_run  = (k < total);
      e_data = e_run && ((k % pe) < he);
      e_done = (k == total);
      check({name, "_enable"}, k, 32'(enable), 32'(e_run));
      check({name, "_data"},   k, 32'(data_signal), 32'(e_data));
      check({name, "_busy"},   k, 32'(busy), 32'(e_run));
      check({name, "_done"},   k, 32'(done), 32'(e_done));
      check({name, "_ack"},    k, 32'(ack_count), exp_ack);
      check({name, "_miss"},   k, 32'(miss_count), exp_miss);
      // Monitor with one cycle of latency, or a coin flip.
      if (mon) occ = mon_q;
      else     occ = 1'($urandom_range(0, 1));
      mon_q = enable & data_signal;
      event_occurred = occ;
      stop  = (k == stop_k);
      start = (k == restart_k);
      // Configuration changes after acceptance must have no effect.
      period      = CNT_W'($urandom);
      high_cycles = CNT_W'($urandom);
      burst_len   = CNT_W'($urandom);
      if (e_run && (k % pe) == 1) begin
        if (occ) exp_ack  = (exp_ack  < ACK_MAX) ? exp_ack + 1  : exp_ack;
        else     exp_miss = (exp_miss < ACK_MAX) ? exp_miss + 1 : exp_miss;
      end
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;
    event_occurred = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    period = '0;
    high_cycles = '0;
    burst_len = '0;
    event_occurred = 1'b0;
    repeat (3) tick();
    check_quiet("reset");
    check("reset_ack",  -1, 32'(ack_count), 32'd0);
    check("reset_miss", -1, 32'(miss_count), 32'd0);
    reset = 1'b0;

    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check_quiet("idle_stop");

    run_burst("basic", 4, 2, 3, -1, -1, 1'b1, 1'b0);
    check("basic_ack_total",  -1, 32'(ack_count), 32'd3);
    check("basic_miss_total", -1, 32'(miss_count), 32'd0);

    run_burst("clamp", 1, 0, 3, -1, -1, 1'b0, 1'b0);
    run_burst("clamp_hi", 3, 9, 2, -1, -1, 1'b0, 1'b0);

    run_burst("stop", 4, 2, 0, 4, -1, 1'b1, 1'b0);
    check("stop_ack_total", -1, 32'(ack_count), 32'd2);

    period = CNT_W'(4);
    high_cycles = CNT_W'(2);
    burst_len = CNT_W'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_mid_data", -1, 32'(data_signal), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_quiet("rst_mid");
    check("rst_mid_ack",  -1, 32'(ack_count), 32'd0);
    check("rst_mid_miss", -1, 32'(miss_count), 32'd0);
    tick();
    check_quiet("rst_after");
    run_burst("rst_restart", 4, 2, 3, -1, -1, 1'b1, 1'b0);

    run_burst("start_stop", 4, 2, 3, -1, 2, 1'b1, 1'b1);
    check("start_stop_ack_total", -1, 32'(ack_count), 32'd3);

    run_burst("saturate", 2, 1, 10, -1, -1, 1'b1, 1'b0);
    check("saturate_ack_total", -1, 32'(ack_count), ACK_MAX);

    run_burst("wrap", 2, 1, 0, 600, -1, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      int sk;
      sk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1;
      run_burst("rand", int'($urandom_range(0, 9)), int'($urandom_range(0, 10)),
                int'($urandom_range(1, 4)), sk, int'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
